// File: rtl/aes_pkg.sv
// GF(2^8) constants, beat mode codes and product helpers for the AES round datapath.
package aes_pkg;

    localparam logic [7:0] GF_POLY  = 8'h1b;
    localparam logic [1:0] MODE_FWD = 2'b00;
    localparam logic [1:0] MODE_INV = 2'b01;
    localparam logic [1:0] MODE_BYP = 2'b10;

    // A state byte together with its doubling chain; everything MixColumns needs.
    typedef struct packed {
        logic [7:0] b;
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
    } gf_prod_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
    endfunction

    function automatic gf_prod_t gf_products(input logic [7:0] b);
        gf_prod_t p;
        p.b  = b;
        p.x2 = xtime(b);
        p.x4 = xtime(p.x2);
        p.x8 = xtime(p.x4);
        return p;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// One 32-bit column of MixColumns / InvMixColumns / bypass from precomputed products.
// Purely combinational; no state, no flow control.
module mix_column_word
    import aes_pkg::*;
(
    input  gf_prod_t [3:0]      prod,
    input  logic [1:0]          mode,
    output logic [3:0][7:0]     res
);

    logic [3:0][7:0] fwd_w;
    logic [3:0][7:0] inv_w;

    // Output byte i uses coefficients applied to bytes i, i+1, i+2, i+3 (mod 4).
    for (genvar i = 0; i < 4; i++) begin : g_byte
        localparam int I1 = (i + 1) % 4;
        localparam int I2 = (i + 2) % 4;
        localparam int I3 = (i + 3) % 4;

        assign fwd_w[i] = prod[i].x2
                        ^ (prod[I1].x2 ^ prod[I1].b)
                        ^ prod[I2].b
                        ^ prod[I3].b;

        assign inv_w[i] = (prod[i].x8  ^ prod[i].x4  ^ prod[i].x2)
                        ^ (prod[I1].x8 ^ prod[I1].x2 ^ prod[I1].b)
                        ^ (prod[I2].x8 ^ prod[I2].x4 ^ prod[I2].b)
                        ^ (prod[I3].x8 ^ prod[I3].b);
    end

    always_comb begin
        res = '0;
        for (int i = 0; i < 4; i++) begin
            case (mode)
                MODE_FWD: res[i] = fwd_w[i];
                MODE_INV: res[i] = inv_w[i];
                MODE_BYP: res[i] = prod[i].b;
                default:  res[i] = prod[i].b;
            endcase
        end
    end

endmodule

// File: rtl/mix_columns_pipe.sv
// Pipelined MixColumns / InvMixColumns / bypass over NUM_COLS columns, tag carried alongside.
// Latency PIPE_STAGES (1 or 2) cycles; stall freezes every register and the input is not sampled.
module mix_columns_pipe
    import aes_pkg::*;
#(
    parameter int NUM_COLS    = 4,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [0:32*NUM_COLS-1]    in_data,
    input  logic                      in_ready,
    input  logic [1:0]                in_mode,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic                      stall,
    output logic [0:32*NUM_COLS-1]    out_data,
    output logic                      out_ready,
    output logic [TAG_W-1:0]          out_tag
);

    localparam int DW = 32 * NUM_COLS;
    localparam int NB = 4 * NUM_COLS;

    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_stages
        $error("mix_columns_pipe: PIPE_STAGES must be 1 or 2");
    end

    gf_prod_t [NB-1:0] in_prod;

    always_comb begin
        in_prod = '0;
        for (int k = 0; k < NB; k++) begin
            in_prod[k] = gf_products(in_data[8*k +: 8]);
        end
    end

    // Inputs to the combine stage: either registered products or straight from the port.
    gf_prod_t [NB-1:0] cmb_prod;
    logic [1:0]        cmb_mode;
    logic [TAG_W-1:0]  cmb_tag;
    logic              cmb_vld;

    if (PIPE_STAGES == 2) begin : g_two
        gf_prod_t [NB-1:0] s1_prod_d, s1_prod_q;
        logic [1:0]        s1_mode_d, s1_mode_q;
        logic [TAG_W-1:0]  s1_tag_d,  s1_tag_q;
        logic              s1_vld_d,  s1_vld_q;

        always_comb begin
            s1_prod_d = s1_prod_q;
            s1_mode_d = s1_mode_q;
            s1_tag_d  = s1_tag_q;
            s1_vld_d  = s1_vld_q;
            if (!stall) begin
                s1_prod_d = in_prod;
                s1_mode_d = in_mode;
                s1_tag_d  = in_tag;
                s1_vld_d  = in_ready;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                s1_prod_q <= '0;
                s1_mode_q <= '0;
                s1_tag_q  <= '0;
                s1_vld_q  <= 1'b0;
            end else begin
                s1_prod_q <= s1_prod_d;
                s1_mode_q <= s1_mode_d;
                s1_tag_q  <= s1_tag_d;
                s1_vld_q  <= s1_vld_d;
            end
        end

        assign cmb_prod = s1_prod_q;
        assign cmb_mode = s1_mode_q;
        assign cmb_tag  = s1_tag_q;
        assign cmb_vld  = s1_vld_q;
    end else begin : g_one
        assign cmb_prod = in_prod;
        assign cmb_mode = in_mode;
        assign cmb_tag  = in_tag;
        assign cmb_vld  = in_ready;
    end

    logic [3:0][7:0] col_res [NUM_COLS];

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        mix_column_word u_col (
            .prod (cmb_prod[4*c +: 4]),
            .mode (cmb_mode),
            .res  (col_res[c])
        );
    end

    logic [0:DW-1] mix_data;

    always_comb begin
        mix_data = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int j = 0; j < 4; j++) begin
                mix_data[8*(4*c+j) +: 8] = col_res[c][j];
            end
        end
    end

    // Output register loads on every unstalled edge, bubbles included, so idle slots stay deterministic.
    logic [0:DW-1]    out_data_d,  out_data_q;
    logic             out_ready_d, out_ready_q;
    logic [TAG_W-1:0] out_tag_d,   out_tag_q;

    always_comb begin
        out_data_d  = out_data_q;
        out_ready_d = out_ready_q;
        out_tag_d   = out_tag_q;
        if (!stall) begin
            out_data_d  = mix_data;
            out_ready_d = cmb_vld;
            out_tag_d   = cmb_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_ready_q <= 1'b0;
            out_tag_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ready_q <= out_ready_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ready = out_ready_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_mix_columns_pipe.sv
// Scoreboard bench: a 4-column 2-stage instance and a 1-column 1-stage instance.
module tb_mix_columns_pipe;

    localparam int PA = 2;
    localparam int PB = 1;

    localparam logic [127:0] F_IN    = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] F_OUT   = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] C_IN    = 128'h8e4da1bc_01010101_9fdc589d_c6c6c6c6;
    localparam logic [127:0] C_OUT   = 128'hdb135345_01010101_f20a225c_c6c6c6c6;
    localparam logic [127:0] M1_IN   = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] M1_OUT  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] M2_IN   = 128'h8e4da1bc_9fdc589d_d5d5d7d6_c6c6c6c6;
    localparam logic [127:0] M2_OUT  = 128'hdb135345_f20a225c_d4d4d4d5_c6c6c6c6;
    localparam logic [127:0] M3_IN   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] M4_IN   = 128'hc6c6c6c6_d4d4d4d5_01010101_db135345;
    localparam logic [127:0] M4_OUT  = 128'hc6c6c6c6_d5d5d7d6_01010101_8e4da1bc;

    typedef struct {
        logic [127:0] dat;
        logic [3:0]   tag;
        int           at;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, b_reset, stall;
    logic [0:127] a_in_data,  a_out_data;
    logic         a_in_ready, a_out_ready;
    logic [1:0]   a_in_mode;
    logic [3:0]   a_in_tag,   a_out_tag;
    logic [0:31]  b_in_data,  b_out_data;
    logic         b_in_ready, b_out_ready;
    logic [1:0]   b_in_mode;
    logic [3:0]   b_in_tag,   b_out_tag;

    mix_columns_pipe #(.NUM_COLS(4), .PIPE_STAGES(PA), .TAG_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .in_data(a_in_data), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_tag(a_in_tag), .stall(stall),
        .out_data(a_out_data), .out_ready(a_out_ready), .out_tag(a_out_tag)
    );

    mix_columns_pipe #(.NUM_COLS(1), .PIPE_STAGES(PB), .TAG_W(4)) u_dut_b (
        .clk(clk), .reset(b_reset), .in_data(b_in_data), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_tag(b_in_tag), .stall(stall),
        .out_data(b_out_data), .out_ready(b_out_ready), .out_tag(b_out_tag)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Advance counters count only edges where the pipeline moved; latency is measured in those.
    int   a_adv = 0, b_adv = 0;
    logic a_adv_q = 1'b0, a_hold_q = 1'b0, b_adv_q = 1'b0, b_hold_q = 1'b0;

    always @(posedge clk) begin
        a_adv_q  <= !stall && !reset;
        a_hold_q <= stall && !reset;
        b_adv_q  <= !stall && !b_reset;
        b_hold_q <= stall && !b_reset;
        if (!stall && !reset)   a_adv <= a_adv + 1;
        if (!stall && !b_reset) b_adv <= b_adv + 1;
    end

    exp_t         qa[$];
    exp_t         qb[$];
    exp_t         ea, eb;
    logic [0:127] a_prev_data;
    logic         a_prev_rdy;
    logic [3:0]   a_prev_tag;
    logic [0:31]  b_prev_data;
    logic         b_prev_rdy;
    logic [3:0]   b_prev_tag;

    always @(negedge clk) begin
        if (a_hold_q) begin
            chk("a_hold_data", a_out_data, a_prev_data);
            chk("a_hold_rdy",  128'(a_out_ready), 128'(a_prev_rdy));
            chk("a_hold_tag",  128'(a_out_tag), 128'(a_prev_tag));
        end else if (a_adv_q && a_out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_beat", 128'(a_out_ready), 128'(0));
            end else begin
                ea = qa.pop_front();
                chk("a_data",    a_out_data, ea.dat);
                chk("a_tag",     128'(a_out_tag), 128'(ea.tag));
                chk("a_latency", 128'(a_adv), 128'(ea.at));
            end
        end
        a_prev_data = a_out_data;
        a_prev_rdy  = a_out_ready;
        a_prev_tag  = a_out_tag;
    end

    always @(negedge clk) begin
        if (b_hold_q) begin
            chk("b_hold_data", 128'(b_out_data), 128'(b_prev_data));
            chk("b_hold_rdy",  128'(b_out_ready), 128'(b_prev_rdy));
        end else if (b_adv_q && b_out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_beat", 128'(b_out_ready), 128'(0));
            end else begin
                eb = qb.pop_front();
                chk("b_data",    128'(b_out_data), eb.dat);
                chk("b_tag",     128'(b_out_tag), 128'(eb.tag));
                chk("b_latency", 128'(b_adv), 128'(eb.at));
            end
        end
        b_prev_data = b_out_data;
        b_prev_rdy  = b_out_ready;
        b_prev_tag  = b_out_tag;
    end

    task automatic send_a(input logic [127:0] d, input logic [1:0] m,
                          input logic [3:0] t, input logic [127:0] x);
        a_in_data  = d;
        a_in_mode  = m;
        a_in_tag   = t;
        a_in_ready = 1'b1;
        @(posedge clk); #1;
        qa.push_back('{dat: x, tag: t, at: a_adv + PA - 1});
    endtask

    task automatic send_b(input logic [31:0] d, input logic [1:0] m,
                          input logic [3:0] t, input logic [31:0] x);
        b_in_data  = d;
        b_in_mode  = m;
        b_in_tag   = t;
        b_in_ready = 1'b1;
        @(posedge clk); #1;
        qb.push_back('{dat: 128'(x), tag: t, at: b_adv + PB - 1});
    endtask

    task automatic idle(input int n);
        a_in_ready = 1'b0;
        b_in_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; b_reset = 1'b1; stall = 1'b0;
        a_in_data = '0; a_in_ready = 1'b0; a_in_mode = '0; a_in_tag = '0;
        b_in_data = '0; b_in_ready = 1'b0; b_in_mode = '0; b_in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("a_rst_data", a_out_data, 128'(0));
        chk("a_rst_rdy",  128'(a_out_ready), 128'(0));
        chk("a_rst_tag",  128'(a_out_tag), 128'(0));
        chk("b_rst_data", 128'(b_out_data), 128'(0));
        chk("b_rst_rdy",  128'(b_out_ready), 128'(0));
        reset = 1'b0; b_reset = 1'b0;
        idle(2);

        // Single beats: forward, inverse, inverse columns, bypass and reserved mode.
        send_a(F_IN,  2'b00, 4'h5, F_OUT);
        idle(3);
        send_a(F_OUT, 2'b01, 4'ha, F_IN);
        send_a(C_IN,  2'b01, 4'h2, C_OUT);
        send_a(M3_IN, 2'b10, 4'h3, M3_IN);
        send_a(F_IN,  2'b11, 4'hc, F_IN);
        idle(4);

        // Back-to-back mixed modes with tags 1..4.
        send_a(M1_IN, 2'b00, 4'h1, M1_OUT);
        send_a(M2_IN, 2'b01, 4'h2, M2_OUT);
        send_a(M3_IN, 2'b10, 4'h3, M3_IN);
        send_a(M4_IN, 2'b00, 4'h4, M4_OUT);
        idle(4);

        // Stall for 3 cycles with both stages full and a beat waiting at the input.
        send_a(M1_IN, 2'b00, 4'h6, M1_OUT);
        send_a(M2_IN, 2'b01, 4'h7, M2_OUT);
        a_in_data = M4_IN; a_in_mode = 2'b00; a_in_tag = 4'h8; a_in_ready = 1'b1;
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b0;
        send_a(M4_IN, 2'b00, 4'h8, M4_OUT);
        send_a(F_OUT, 2'b01, 4'h9, F_IN);
        idle(4);

        // Reset with one beat in stage 1 and one at the input.
        send_a(M1_IN, 2'b00, 4'hb, M1_OUT);
        send_a(M2_IN, 2'b01, 4'hc, M2_OUT);
        send_a(M4_IN, 2'b00, 4'hd, M4_OUT);
        a_in_data = F_IN; a_in_mode = 2'b00; a_in_tag = 4'he; a_in_ready = 1'b1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("a_midrst_rdy",  128'(a_out_ready), 128'(0));
        chk("a_midrst_data", a_out_data, 128'(0));
        chk("a_midrst_tag",  128'(a_out_tag), 128'(0));
        qa.delete();
        reset = 1'b0;
        idle(5);
        send_a(F_IN, 2'b00, 4'hf, F_OUT);
        idle(4);

        // Single-column, single-stage instance.
        send_b(32'hdb135345, 2'b00, 4'h1, 32'h8e4da1bc);
        send_b(32'h8e4da1bc, 2'b01, 4'h2, 32'hdb135345);
        send_b(32'h01010101, 2'b01, 4'h3, 32'h01010101);
        send_b(32'h2d26314c, 2'b10, 4'h4, 32'h2d26314c);
        send_b(32'hd4d4d4d5, 2'b11, 4'h5, 32'hd4d4d4d5);
        send_b(32'hd4d4d4d5, 2'b00, 4'h6, 32'hd5d5d7d6);
        idle(2);
        send_b(32'hf20a225c, 2'b00, 4'h7, 32'h9fdc589d);
        b_in_data = 32'hc6c6c6c6; b_in_mode = 2'b00; b_in_tag = 4'h8; b_in_ready = 1'b1;
        stall = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b0;
        send_b(32'hc6c6c6c6, 2'b00, 4'h8, 32'hc6c6c6c6);
        send_b(32'h2d26314c, 2'b00, 4'h9, 32'h4d7ebdf8);
        b_in_data = 32'hdb135345; b_in_mode = 2'b00; b_in_tag = 4'ha; b_in_ready = 1'b1;
        b_reset = 1'b1;
        @(posedge clk); #1;
        chk("b_midrst_rdy",  128'(b_out_ready), 128'(0));
        chk("b_midrst_data", 128'(b_out_data), 128'(0));
        qb.delete();
        b_reset = 1'b0;
        idle(5);

        chk("a_queue_empty", 128'(qa.size()), 128'(0));
        chk("b_queue_empty", 128'(qb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mix_columns_pipe.md
Name: mix_columns_pipe

Overview:
- Parametrised, pipelined successor to the round MixColumns stage, for the AES-256 / AES-GCM round datapath.
- Per beat it performs one of three operations on NUM_COLS 32-bit columns: forward MixColumns, InvMixColumns, or bypass (for the final round).
- Latency is 1 or 2 cycles, selectable by parameter.
- A global stall freezes the pipeline, and a sideband tag (e.g. round index) travels with each beat.

Parameters:
- NUM_COLS, 4: number of columns per beat; data width DW = 32*NUM_COLS.
- PIPE_STAGES, 2: latency in cycles.
  - Legal values are 1 and 2; any other value is a compile-time error.
  - 1: a single output register.
  - 2: stage 1 registers the xtime products, stage 2 combines them and registers the result.
- TAG_W, 4: width of the sideband tag.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  [0:DW-1]  state bytes.
  - Byte k occupies in_data[8k:8k+7], with bit 8k as the byte MSB.
  - Column c is bytes 4c..4c+3.
- in_ready  in  1  input beat valid.
- in_mode  in  2  operation select: 00 forward, 01 inverse, 10 bypass, 11 reserved (treated as bypass).
- in_tag  in  TAG_W  sideband value, carried unchanged.
- stall  in  1  global pipeline hold from downstream.
- out_data  out  [0:DW-1]  result, using the same byte and column ordering as in_data.
- out_ready  out  1  output beat valid.
- out_tag  out  TAG_W  tag of the output beat.

Behaviour:
- Reset values: out_data = 0, out_ready = 0, out_tag = 0.
  - All internal stage valid bits, data, mode and tag registers are 0.
  - Reset has priority over stall.
  - Reset asserted mid-operation discards all in-flight beats at the next edge; there is no partial output.
- Field arithmetic: GF(2^8) with reduction polynomial 0x11B.
  - xtime(b) = (b<<1) ^ (b[MSB] ? 8'h1b : 0).
  - Derived products: x3 = x2^b, x9 = x8^b, x11 = x8^x2^b, x13 = x8^x4^b, x14 = x8^x4^x2.
- Forward operation, per column (a0..a3 → r0..r3):
  - r0 = 2a0^3a1^a2^a3
  - r1 = a0^2a1^3a2^a3
  - r2 = a0^a1^2a2^3a3
  - r3 = 3a0^a1^a2^2a3
- Inverse operation, per column:
  - r0 = 14a0^11a1^13a2^9a3
  - the coefficient row rotates right by one for each subsequent output byte.
- Bypass: r = a.
- Mode is captured with each beat and travels with it, so modes may change on every beat.
- Pipeline advance:
  - When stall = 0, each stage loads from its predecessor.
  - Stage 1 captures in_data, in_mode, in_tag and in_ready.
  - With no stall, latency is exactly PIPE_STAGES cycles from the in_ready edge to the out_ready edge.
  - Throughput is one beat per cycle.
- Stall = 1:
  - Every register, including out_data, out_ready and out_tag, holds its value.
  - The input is not sampled; upstream must hold its beat and sees the same stall.
  - A beat presented during stall is captured on the first edge with stall = 0.
- Bubbles: when in_ready = 0, a bubble propagates.
  - out_ready = 0 for that slot.
  - out_data and out_tag in a bubble slot are don't-care, but must be deterministic: the stage registers load regardless of valid.
- Back-to-back beats with alternating modes must each produce the correct, independent result with no cross-contamination.

Decomposition:
- Shared package aes_pkg:
  - GF reduction constant 8'h1b
  - mode encodings MODE_FWD = 2'b00, MODE_INV = 2'b01, MODE_BYP = 2'b10
  - xtime function
- Sub-module mix_column_word: one 32-bit column, combinational.
  - Takes the precomputed products (x2, x4, x8 per byte) plus mode, and produces 32 result bits.
  - Instantiated NUM_COLS times by a generate loop.
  - The top level owns all registers, the stall logic and the valid/tag pipeline.

Test Plan:
- Forward, NUM_COLS = 4: in_data d4bf5d30e0b452aeb84111f11e2798e5 with mode 00 → out_data 046681e5e0cb199a48f8d37a2806264c, out_ready after exactly PIPE_STAGES cycles, tag preserved.
- Inverse: in_data 046681e5e0cb199a48f8d37a2806264c with mode 01 → out_data d4bf5d30e0b452aeb84111f11e2798e5. Also apply single columns: 8e4da1bc → db135345, and 01010101 → 01010101.
- Bypass and reserved: modes 10 and 11 on any vector → out_data equals in_data.
- Mixed stream: back-to-back beats (fwd db135345…, inv 8e4da1bc…, byp, fwd c6c6c6c6…), tags 1 to 4 → outputs in order with the correct per-mode results and matching tags.
- Stall: assert stall for 3 cycles with the pipeline full. Outputs and out_ready must be frozen, with no beat lost or duplicated, and the sequence must resume on release.
- Reset with two beats in flight: out_ready = 0 and out_data = 0 on the next edge, and no stale beat emerges afterwards. Repeat for NUM_COLS = 1 and for PIPE_STAGES = 1.
